tspp_fetch_sequencer: RTL and testbench
=======================================

# tspp_fetch_sequencer

Fetch-side responder for the two-stage pipeline hazard unit. Owns the program counter, drives the instruction memory bus, and reports fetch exceptions (`fault_insn`, `mal_insn`) and memory stall (`i_mem_busy`) back to the hazard unit. Obeys the hazard unit's control outputs: `pc_en`, `npc_sel`, `if_ex_stall`, `if_ex_flush`, `priv_pc`, `insert_priv_pc` and `iren`. Holds the IF/EX pipeline latch consumed by the execute stage.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0200: PC value loaded at reset.
- `NOP_INSN`, default 32'h0000_0013: instruction placed in the latch on bubble or flush.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `pc_en`, `npc_sel`, `if_ex_stall`, `if_ex_flush`, `insert_priv_pc`, `iren`  in  1 each  hazard-unit controls.
- `priv_pc`  in  32  trap/return target.
- `brj_addr`  in  32  resolved branch/jump target from execute.
- `i_mem_busy`  out  1  fetch waiting on memory.
- `fault_insn`, `mal_insn`  out  1 each  fetch exceptions.
- `epc_f`, `badaddr_f`  out  32  PC of the faulting fetch.
- `rv32c_ready`  out  1  constant 1; compressed instructions are not supported.
- `imem_ren`  out  1  read request.
- `imem_addr`  out  32  read address.
- `imem_rdata`  in  32  read data.
- `imem_busy`  in  1  transfer not complete.
- `imem_error`  in  1  bus error; valid when `imem_busy`=0.
- `ifex_valid`  out  1  IF/EX latch holds a real instruction.
- `ifex_instr`, `ifex_pc`, `ifex_pc4`  out  32 each  IF/EX latch contents.

## Operation
- State machine with three states: FETCH, HOLD and DRAIN. Registers: `pc`, `pend_pc`, `buf_word`, `buf_err`, and the IF/EX latch.
- Next PC: `priv_pc` if `insert_priv_pc`; else `brj_addr` if `npc_sel`; else `pc`+4. Addition wraps modulo 2^32.
- `mis` = (`pc[1:0]` != 0).
- `imem_addr` = `pc` in every state. `epc_f` = `badaddr_f` = `pc`.

FETCH:
- `imem_ren` = `iren` & !`mis`.
- `mal_insn` = `iren` & `mis`. No bus request is issued.
- The transfer completes when `imem_ren` & !`imem_busy`.
- `i_mem_busy` = `imem_ren` & `imem_busy`.
- On completion with `pc_en`=1: the word is delivered this cycle and `pc` takes the next PC.
- On completion with `pc_en`=0: capture `imem_rdata` into `buf_word` and `imem_error` into `buf_err`, then go to HOLD.
- When `pc_en`=1 and `imem_ren`=0: `pc` takes the next PC. This is the misaligned-trap redirect or `iren`=0.
- When `pc_en`=1 and the transfer is still busy: store the next PC in `pend_pc` and go to DRAIN.

HOLD:
- `imem_ren`=0 and `i_mem_busy`=0. The buffered word is presented.
- On `pc_en`: deliver `buf_word`, `pc` takes the next PC, go to FETCH.

DRAIN:
- `imem_ren`=1 with `imem_addr` unchanged. `i_mem_busy`=1.
- `pc_en` with `insert_priv_pc` or `npc_sel` overwrites `pend_pc`. A plain `pc_en` is ignored.
- On completion: discard the data, `pc` ← `pend_pc`, go to FETCH.

Fault reporting:
- `fault_insn` = 1 in the cycle a word with its error flag set is presented, in FETCH completion or in HOLD.
- An errored word is never loaded as valid.

IF/EX latch, with priority flush > stall > load:
- `if_ex_flush`: `ifex_valid` ← 0, `ifex_instr` ← `NOP_INSN`.
- `if_ex_stall`: hold.
- Otherwise, if a good word is delivered: load valid=1, the instruction, `pc`, and `pc`+4.
- Otherwise: bubble, with valid=0 and instruction = `NOP_INSN`. `ifex_pc` and `ifex_pc4` hold their values.

## Timing
Reset values (asserting `RST` at any time, including mid-transfer, forces these immediately):
- state FETCH, `pc` = `RESET_PC`, `pend_pc` = 0, `buf_word` = 0, `buf_err` = 0.
- `ifex_valid` = 0, `ifex_instr` = `NOP_INSN`, `ifex_pc` = 0, `ifex_pc4` = 0.
- A bus transfer in progress at reset is abandoned.

Latency:
- Zero-wait memory: 1 instruction per cycle. A word is requested in cycle N and is in the latch after edge N.
- N wait states: `i_mem_busy` is high for N cycles, and the latch loads bubbles unless stalled.

Simultaneous events:
- Flush and word delivery in the same cycle: `pc` still advances and the latch takes the bubble.
- `insert_priv_pc` and `npc_sel` together: `priv_pc` wins.

All handshake outputs are combinational from state, `pc`, and the bus inputs. There is no combinational path from `pc_en` to `imem_ren`.

## Test plan
- Reset, `iren`=1, zero-wait memory returning 0x00A00093 at 0x200 → `ifex_valid`=1, `ifex_instr`=0x00A00093, `ifex_pc`=0x200, `ifex_pc4`=0x204 after the first edge. `pc`=0x204.
- `imem_busy` high for 3 cycles → `i_mem_busy`=1 for 3 cycles, 3 bubbles in the latch, load on the 4th cycle.
- Completion with `pc_en`=0 for 2 cycles, then `pc_en`=1 → HOLD for 2 cycles with `imem_ren`=0, then the buffered word is loaded. No second bus read.
- `npc_sel`=1 with `brj_addr`=0x302 → next cycle `mal_insn`=1, `epc_f`=`badaddr_f`=0x302, `imem_ren`=0. A following `insert_priv_pc` with `priv_pc`=0x400 → `pc`=0x400.
- Completion with `imem_error`=1 → `fault_insn`=1, latch bubble, `epc_f`=fetch PC.
- `insert_priv_pc` with `priv_pc`=0x800 while `imem_busy`=1 → enter DRAIN, `imem_addr` held. On completion the data is discarded and the next fetch is at 0x800. `RST` pulse mid-DRAIN → `pc`=0x200 immediately.

Source files
------------

// File: rtl/tspp_fetch_sequencer.sv
// Fetch-side sequencer: owns the PC, runs the instruction-memory read and fills
// the IF/EX latch under control of the hazard unit.
module tspp_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        pc_en,
    input  logic        npc_sel,
    input  logic        if_ex_stall,
    input  logic        if_ex_flush,
    input  logic        insert_priv_pc,
    input  logic        iren,
    input  logic [31:0] priv_pc,
    input  logic [31:0] brj_addr,
    output logic        i_mem_busy,
    output logic        fault_insn,
    output logic        mal_insn,
    output logic [31:0] epc_f,
    output logic [31:0] badaddr_f,
    output logic        rv32c_ready,
    output logic        imem_ren,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_busy,
    input  logic        imem_error,
    output logic        ifex_valid,
    output logic [31:0] ifex_instr,
    output logic [31:0] ifex_pc,
    output logic [31:0] ifex_pc4,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic [31:0] buf_word;
    logic        buf_err;

    logic        mis;
    logic [31:0] npc;
    logic        done;
    logic        deliver;
    logic [31:0] word;
    logic        word_err;
    logic        redirect;

    // Bus handshake: a read is requested while imem_ren=1 and completes in the
    // first cycle with imem_ren=1 and imem_busy=0; imem_rdata/imem_error are
    // sampled only in that cycle and imem_addr is stable until then.
    assign mis         = (pc[1:0] != 2'b00);
    assign redirect    = insert_priv_pc | npc_sel;
    assign npc         = insert_priv_pc ? priv_pc : (npc_sel ? brj_addr : pc + 32'd4);
    assign imem_addr   = pc;
    assign epc_f       = pc;
    assign badaddr_f   = pc;
    assign rv32c_ready = 1'b1;
    assign state_dbg   = state;

    always_comb begin
        imem_ren   = 1'b0;
        i_mem_busy = 1'b0;
        mal_insn   = 1'b0;
        case (state)
            FETCH: begin
                imem_ren   = iren & ~mis;
                i_mem_busy = iren & ~mis & imem_busy;
                mal_insn   = iren & mis;
            end
            DRAIN: begin
                imem_ren   = 1'b1;
                i_mem_busy = 1'b1;
            end
            default: begin
                imem_ren   = 1'b0;
                i_mem_busy = 1'b0;
            end
        endcase
    end

    assign done       = (state == FETCH) & imem_ren & ~imem_busy;
    assign word       = (state == HOLD) ? buf_word : imem_rdata;
    assign word_err   = (state == HOLD) ? buf_err : imem_error;
    assign deliver    = (done & pc_en) | ((state == HOLD) & pc_en);
    assign fault_insn = (done & imem_error) | ((state == HOLD) & buf_err);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            pend_pc  <= 32'd0;
            buf_word <= 32'd0;
            buf_err  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imem_ren && !imem_busy) begin
                        if (pc_en) begin
                            pc <= npc;
                        end else begin
                            buf_word <= imem_rdata;
                            buf_err  <= imem_error;
                            state    <= HOLD;
                        end
                    end else if (imem_ren) begin
                        if (pc_en) begin
                            pend_pc <= npc;
                            state   <= DRAIN;
                        end
                    end else if (pc_en) begin
                        pc <= npc;
                    end
                end
                HOLD: begin
                    if (pc_en) begin
                        pc    <= npc;
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    // A redirect landing on the completion cycle must still win.
                    if (pc_en && redirect) begin
                        pend_pc <= npc;
                    end
                    if (!imem_busy) begin
                        pc    <= (pc_en && redirect) ? npc : pend_pc;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ifex_valid <= 1'b0;
            ifex_instr <= NOP_INSN;
            ifex_pc    <= 32'd0;
            ifex_pc4   <= 32'd0;
        end else if (if_ex_flush) begin
            ifex_valid <= 1'b0;
            ifex_instr <= NOP_INSN;
        end else if (!if_ex_stall) begin
            if (deliver && !word_err) begin
                ifex_valid <= 1'b1;
                ifex_instr <= word;
                ifex_pc    <= pc;
                ifex_pc4   <= pc + 32'd4;
            end else begin
                ifex_valid <= 1'b0;
                ifex_instr <= NOP_INSN;
            end
        end
    end

endmodule

// File: tb/tb_tspp_fetch_sequencer.sv
// Directed bench for tspp_fetch_sequencer: a cycle-by-cycle vector table
// plus hand-written reset-in-DRAIN and PC-wrap sequences.
module tb_tspp_fetch_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        pc_en = 0, npc_sel = 0, if_ex_stall = 0, if_ex_flush = 0;
  logic        insert_priv_pc = 0, iren = 0;
  logic [31:0] priv_pc = 0, brj_addr = 0, imem_rdata = 0;
  logic        imem_busy = 0, imem_error = 0;
  logic        i_mem_busy, fault_insn, mal_insn, rv32c_ready, imem_ren;
  logic [31:0] epc_f, badaddr_f, imem_addr;
  logic        ifex_valid;
  logic [31:0] ifex_instr, ifex_pc, ifex_pc4;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  tspp_fetch_sequencer dut (
    .CLK(CLK), .RST(RST), .pc_en(pc_en), .npc_sel(npc_sel),
    .if_ex_stall(if_ex_stall), .if_ex_flush(if_ex_flush),
    .insert_priv_pc(insert_priv_pc), .iren(iren), .priv_pc(priv_pc),
    .brj_addr(brj_addr), .i_mem_busy(i_mem_busy), .fault_insn(fault_insn),
    .mal_insn(mal_insn), .epc_f(epc_f), .badaddr_f(badaddr_f),
    .rv32c_ready(rv32c_ready), .imem_ren(imem_ren), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_busy(imem_busy), .imem_error(imem_error),
    .ifex_valid(ifex_valid), .ifex_instr(ifex_instr), .ifex_pc(ifex_pc),
    .ifex_pc4(ifex_pc4), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ctl bits: pc_en npc_sel stall flush ipriv iren busy err
  // comb bits: imem_ren i_mem_busy fault_insn mal_insn
  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] priv;
    logic [31:0] brj;
    logic [31:0] rdata;
    logic [3:0]  comb;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ipc4;
    logic [1:0]  st;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [7:0] ctl, input logic [31:0] priv, brj, rdata,
                         input logic [3:0] comb, input logic [31:0] addr,
                         input logic valid, input logic [31:0] instr, ipc, ipc4,
                         input logic [1:0] st);
    vec_t v;
    v.ctl = ctl; v.priv = priv; v.brj = brj; v.rdata = rdata; v.comb = comb;
    v.addr = addr; v.valid = valid; v.instr = instr; v.ipc = ipc; v.ipc4 = ipc4;
    v.st = st;
    vecs.push_back(v);
  endtask

  // driver
  task automatic drive(input logic [7:0] ctl, input logic [31:0] priv, brj, rdata);
    {pc_en, npc_sel, if_ex_stall, if_ex_flush, insert_priv_pc, iren, imem_busy, imem_error} = ctl;
    priv_pc = priv;
    brj_addr = brj;
    imem_rdata = rdata;
  endtask

  // scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  initial begin
    // ctl                 priv      brj       rdata        comb     addr      v instr        ipc       ipc4      st
    add_vec(8'b10000100, 32'h0, 32'h0, 32'h00A00093, 4'b1000, 32'h200, 1, 32'h00A00093, 32'h200, 32'h204, 0);
    add_vec(8'b10000100, 32'h0, 32'h0, 32'h00100113, 4'b1000, 32'h204, 1, 32'h00100113, 32'h204, 32'h208, 0);
    add_vec(8'b00000110, 32'h0, 32'h0, 32'h0,        4'b1100, 32'h208, 0, NOP,          32'h204, 32'h208, 0);
    add_vec(8'b00000110, 32'h0, 32'h0, 32'h0,        4'b1100, 32'h208, 0, NOP,          32'h204, 32'h208, 0);
    add_vec(8'b00000110, 32'h0, 32'h0, 32'h0,        4'b1100, 32'h208, 0, NOP,          32'h204, 32'h208, 0);
    add_vec(8'b10000100, 32'h0, 32'h0, 32'h00208193, 4'b1000, 32'h208, 1, 32'h00208193, 32'h208, 32'h20C, 0);
    add_vec(8'b00000100, 32'h0, 32'h0, 32'h00310233, 4'b1000, 32'h20C, 0, NOP,          32'h208, 32'h20C, 1);
    add_vec(8'b00000100, 32'h0, 32'h0, 32'hDEADBEEF, 4'b0000, 32'h20C, 0, NOP,          32'h208, 32'h20C, 1);
    add_vec(8'b10000100, 32'h0, 32'h0, 32'hDEADBEEF, 4'b0000, 32'h20C, 1, 32'h00310233, 32'h20C, 32'h210, 0);
    add_vec(8'b11010100, 32'h0, 32'h302, 32'h11111111, 4'b1000, 32'h210, 0, NOP,        32'h20C, 32'h210, 0);
    add_vec(8'b00000100, 32'h0, 32'h0, 32'h0,        4'b0001, 32'h302, 0, NOP,          32'h20C, 32'h210, 0);
    add_vec(8'b11001100, 32'h400, 32'h500, 32'h0,    4'b0001, 32'h302, 0, NOP,          32'h20C, 32'h210, 0);
    add_vec(8'b10000101, 32'h0, 32'h0, 32'h22222222, 4'b1010, 32'h400, 0, NOP,          32'h20C, 32'h210, 0);
    add_vec(8'b10000100, 32'h0, 32'h0, 32'h33333333, 4'b1000, 32'h404, 1, 32'h33333333, 32'h404, 32'h408, 0);
    add_vec(8'b00100000, 32'h0, 32'h0, 32'h0,        4'b0000, 32'h408, 1, 32'h33333333, 32'h404, 32'h408, 0);
    add_vec(8'b00000000, 32'h0, 32'h0, 32'h0,        4'b0000, 32'h408, 0, NOP,          32'h404, 32'h408, 0);
    add_vec(8'b00000101, 32'h0, 32'h0, 32'h77777777, 4'b1010, 32'h408, 0, NOP,          32'h404, 32'h408, 1);
    add_vec(8'b10000100, 32'h0, 32'h0, 32'h0,        4'b0010, 32'h408, 0, NOP,          32'h404, 32'h408, 0);
    add_vec(8'b10001110, 32'h800, 32'h0, 32'h0,      4'b1100, 32'h40C, 0, NOP,          32'h404, 32'h408, 2);
    add_vec(8'b10000110, 32'h0, 32'h0, 32'h0,        4'b1100, 32'h40C, 0, NOP,          32'h404, 32'h408, 2);
    add_vec(8'b00000100, 32'h0, 32'h0, 32'h44444444, 4'b1100, 32'h40C, 0, NOP,          32'h404, 32'h408, 0);
    add_vec(8'b10000100, 32'h0, 32'h0, 32'h55555555, 4'b1000, 32'h800, 1, 32'h55555555, 32'h800, 32'h804, 0);
    add_vec(8'b10000100, 32'h0, 32'h0, 32'h66666666, 4'b1000, 32'h804, 1, 32'h66666666, 32'h804, 32'h808, 0);

    // reset state
    #12;
    check("rst_valid", {31'd0, ifex_valid}, 32'd0);
    check("rst_instr", ifex_instr, NOP);
    check("rst_ifpc", ifex_pc, 32'd0);
    check("rst_ifpc4", ifex_pc4, 32'd0);
    check("rst_addr", imem_addr, 32'h200);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    check("rv32c_ready", {31'd0, rv32c_ready}, 32'd1);

    @(negedge CLK);
    RST = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctl, vecs[i].priv, vecs[i].brj, vecs[i].rdata);
      #1;
      check($sformatf("v%0d_comb", i), {28'd0, imem_ren, i_mem_busy, fault_insn, mal_insn},
            {28'd0, vecs[i].comb});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      check($sformatf("v%0d_epc", i), epc_f, vecs[i].addr);
      check($sformatf("v%0d_badaddr", i), badaddr_f, vecs[i].addr);
      @(posedge CLK);
      #1;
      check($sformatf("v%0d_valid", i), {31'd0, ifex_valid}, {31'd0, vecs[i].valid});
      check($sformatf("v%0d_instr", i), ifex_instr, vecs[i].instr);
      check($sformatf("v%0d_ifpc", i), ifex_pc, vecs[i].ipc);
      check($sformatf("v%0d_ifpc4", i), ifex_pc4, vecs[i].ipc4);
      check($sformatf("v%0d_state", i), {30'd0, state_dbg}, {30'd0, vecs[i].st});
      @(negedge CLK);
    end

    // reset pulse in the middle of a DRAIN
    drive(8'b10001110, 32'h900, 32'h0, 32'h0);
    @(posedge CLK);
    #1;
    check("drain_enter", {30'd0, state_dbg}, 32'd2);
    #2;
    RST = 1'b1;
    #1;
    check("rst_mid_state", {30'd0, state_dbg}, 32'd0);
    check("rst_mid_addr", imem_addr, 32'h200);
    check("rst_mid_ren", {31'd0, imem_ren}, 32'd1);
    check("rst_mid_valid", {31'd0, ifex_valid}, 32'd0);
    check("rst_mid_ifpc", ifex_pc, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    drive(8'b10000100, 32'h0, 32'h0, 32'h00A00093);
    @(posedge CLK);
    #1;
    check("post_rst_valid", {31'd0, ifex_valid}, 32'd1);
    check("post_rst_ifpc", ifex_pc, 32'h200);

    // PC arithmetic wraps at the top of the address space
    @(negedge CLK);
    drive(8'b10001000, 32'hFFFF_FFFC, 32'h0, 32'h0);
    #1;
    check("wrap_no_mal", {31'd0, mal_insn}, 32'd0);
    @(negedge CLK);
    drive(8'b10000100, 32'h0, 32'h0, 32'h00000093);
    #1;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    @(posedge CLK);
    #1;
    check("wrap_ifpc4", ifex_pc4, 32'd0);
    @(negedge CLK);
    #1;
    check("wrap_next_addr", imem_addr, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
